ofdm_cp_insert: RTL and testbench

OFDM_CP_INSERT -- requirements
Module: ofdm_cp_insert

---
 rtl/ofdm_pkg.sv | 14 +
 rtl/ram_1p_sync.sv | 27 ++
 rtl/setting_reg.sv | 25 ++
 rtl/ofdm_cp_insert.sv | 204 ++++++++++++++++++++
 tb/tb_ofdm_cp_insert.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM cyclic-prefix inserter: FSM encoding and
// the power-up frame/gap lengths.
package ofdm_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_CP   = 2'd1,
    ST_BODY = 2'd2
  } cp_state_e;

  localparam int DEF_FRAME_LEN = 64;
  localparam int DEF_GAP_LEN   = 16;

endpackage

// File: rtl/ram_1p_sync.sv
// Single-port RAM with registered read; the read register holds while en=0
// so it can serve as a stallable pipeline stage.
module ram_1p_sync #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  logic [WIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/setting_reg.sv
// Settings-bus register: loads the low bits of the bus data when its address
// is written.
module setting_reg #(
  parameter int               my_addr  = 0,
  parameter int               awidth   = 8,
  parameter int               width    = 32,
  parameter logic [width-1:0] at_reset = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic [awidth-1:0] addr,
  input  logic [width-1:0]  in,
  output logic [width-1:0]  out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= at_reset;
    end else if (strobe && (addr == awidth'(my_addr))) begin
      out <= in;
    end
  end

endmodule

// File: rtl/ofdm_cp_insert.sv
// Buffers one OFDM symbol, then replays its tail (cyclic prefix) followed by
// the whole symbol on an AXI-stream output.
module ofdm_cp_insert
  import ofdm_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int MAX_LEN_LOG2 = 8,
  parameter int SR_FRAME_LEN = 16,
  parameter int SR_GAP_LEN   = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             err_short,
  output cp_state_e        dbg_state
);

  localparam int A = MAX_LEN_LOG2;
  localparam int L = MAX_LEN_LOG2 + 1;
  localparam logic [L-1:0] MAX_LEN = L'(2**A);

  // Valid/ready: a word moves on a rising clk edge exactly when valid and
  // ready are both high; a source holding valid keeps its data unchanged.

  function automatic logic [L-1:0] sat_frame(input logic [L-1:0] v);
    if (v == '0) return L'(1);
    else if (v > MAX_LEN) return MAX_LEN;
    else return v;
  endfunction

  cp_state_e        state, state_n;
  logic [L-1:0]     frame_len_reg, gap_len_reg;
  logic [L-1:0]     frame_q, gap_q;
  logic [L-1:0]     reg_frame_sat, reg_gap_sat, cur_frame, cur_gap;
  logic [L-1:0]     wr_cnt, wr_cnt_n, rd_cnt, rd_cnt_n;
  logic             in_acc, first, err_n;
  logic             rd_want, rd_go, rd_last;
  logic [A-1:0]     rd_addr, ram_addr;
  logic [WIDTH-1:0] ram_q;
  logic             valid_a, last_a;
  logic             b_load, a_adv;
  logic             unused_set;

  assign unused_set = ^set_data[31:L];

  setting_reg #(
    .my_addr (SR_FRAME_LEN),
    .awidth  (8),
    .width   (L),
    .at_reset(L'(DEF_FRAME_LEN))
  ) u_sr_frame (
    .clk   (clk),
    .rst   (reset),
    .strobe(set_stb),
    .addr  (set_addr),
    .in    (set_data[L-1:0]),
    .out   (frame_len_reg)
  );

  setting_reg #(
    .my_addr (SR_GAP_LEN),
    .awidth  (8),
    .width   (L),
    .at_reset(L'(DEF_GAP_LEN))
  ) u_sr_gap (
    .clk   (clk),
    .rst   (reset),
    .strobe(set_stb),
    .addr  (set_addr),
    .in    (set_data[L-1:0]),
    .out   (gap_len_reg)
  );

  // On the first sample of a frame the live registers apply; afterwards the
  // lengths latched with that sample do, so mid-frame writes wait a frame.
  assign reg_frame_sat = sat_frame(frame_len_reg);
  assign reg_gap_sat   = (gap_len_reg > reg_frame_sat) ? reg_frame_sat : gap_len_reg;
  assign first         = (wr_cnt == '0);
  assign cur_frame     = first ? reg_frame_sat : frame_q;
  assign cur_gap       = first ? reg_gap_sat : gap_q;

  assign i_tready  = (state == ST_FILL);
  assign in_acc    = (state == ST_FILL) && i_tvalid;
  assign dbg_state = state;

  // Two-stage output pipe: RAM read register (stage A) then output register.
  assign b_load = !o_tvalid || o_tready;
  assign a_adv  = !valid_a || b_load;
  assign rd_go  = rd_want && a_adv;

  always_comb begin
    state_n  = state;
    wr_cnt_n = wr_cnt;
    rd_cnt_n = rd_cnt;
    err_n    = 1'b0;
    rd_want  = 1'b0;
    rd_addr  = '0;
    rd_last  = 1'b0;
    case (state)
      ST_FILL: begin
        if (i_tvalid) begin
          if (wr_cnt == cur_frame - L'(1)) begin
            wr_cnt_n = '0;
            rd_cnt_n = '0;
            state_n  = (cur_gap == '0) ? ST_BODY : ST_CP;
          end else if (i_tlast) begin
            err_n    = 1'b1;
            wr_cnt_n = '0;
          end else begin
            wr_cnt_n = wr_cnt + L'(1);
          end
        end
      end
      ST_CP: begin
        rd_want = 1'b1;
        rd_addr = A'(frame_q - gap_q + rd_cnt);
        if (a_adv) begin
          if (rd_cnt == gap_q - L'(1)) begin
            rd_cnt_n = '0;
            state_n  = ST_BODY;
          end else begin
            rd_cnt_n = rd_cnt + L'(1);
          end
        end
      end
      ST_BODY: begin
        if (rd_cnt < frame_q) begin
          rd_want = 1'b1;
          rd_addr = rd_cnt[A-1:0];
          rd_last = (rd_cnt == frame_q - L'(1));
          if (a_adv) rd_cnt_n = rd_cnt + L'(1);
        end
        if (o_tvalid && o_tready && o_tlast) begin
          rd_cnt_n = '0;
          state_n  = ST_FILL;
        end
      end
      default: begin
        state_n  = ST_FILL;
        wr_cnt_n = '0;
        rd_cnt_n = '0;
      end
    endcase
  end

  assign ram_addr = in_acc ? wr_cnt[A-1:0] : rd_addr;

  ram_1p_sync #(
    .WIDTH (WIDTH),
    .AWIDTH(A)
  ) u_ram (
    .clk (clk),
    .en  (in_acc || rd_go),
    .we  (in_acc),
    .addr(ram_addr),
    .din (i_tdata),
    .dout(ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      frame_q   <= L'(DEF_FRAME_LEN);
      gap_q     <= L'(DEF_GAP_LEN);
      err_short <= 1'b0;
      valid_a   <= 1'b0;
      last_a    <= 1'b0;
      o_tvalid  <= 1'b0;
      o_tlast   <= 1'b0;
      o_tdata   <= '0;
    end else begin
      state     <= state_n;
      wr_cnt    <= wr_cnt_n;
      rd_cnt    <= rd_cnt_n;
      err_short <= err_n;
      if (in_acc && first) begin
        frame_q <= reg_frame_sat;
        gap_q   <= reg_gap_sat;
      end
      if (a_adv) begin
        valid_a <= rd_go;
        last_a  <= rd_go && rd_last;
      end
      if (b_load) begin
        o_tvalid <= valid_a;
        o_tlast  <= valid_a && last_a;
        if (valid_a) o_tdata <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_cp_insert.sv
// Bench for ofdm_cp_insert: random and ramp frames against a queue-based
// model of "tail of the symbol, then the whole symbol".
module tb_ofdm_cp_insert;
  import ofdm_pkg::*;

  localparam int WIDTH = 32;
  localparam int W     = WIDTH + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             set_stb = 1'b0;
  logic [7:0]       set_addr = '0;
  logic [31:0]      set_data = '0;
  logic [WIDTH-1:0] i_tdata = '0;
  logic             i_tlast = 1'b0;
  logic             i_tvalid = 1'b0;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready = 1'b1;
  logic             err_short;
  cp_state_e        dbg_state;

  ofdm_cp_insert #(
    .WIDTH(WIDTH), .MAX_LEN_LOG2(8), .SR_FRAME_LEN(16), .SR_GAP_LEN(17)
  ) dut (
    .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready), .o_tdata(o_tdata),
    .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .err_short(err_short), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [WIDTH-1:0] tx_buf [0:511];
  int  model_frame = 64;
  int  model_gap   = 16;
  bit  rdy_always  = 1'b1;
  int  err_seen    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // output backpressure driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      o_tready = rdy_always ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // scoreboard / monitor
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_word;
  bit           out_started = 1'b0;
  int           bubbles = 0;
  always @(negedge clk) begin
    logic [W-1:0] w;
    if (!reset) begin
      if (err_short) err_seen++;
      if (prev_stall) begin
        check("hold_valid", 64'(o_tvalid), 64'd1);
        check("hold_data", 64'({o_tlast, o_tdata}), 64'(prev_word));
      end
      if (o_tvalid && o_tready) begin
        check("out_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("out_word", 64'({o_tlast, o_tdata}), 64'(w));
        end
        out_started = 1'b1;
        if (o_tlast) begin
          if (rdy_always) check("gap_free", 64'(bubbles), 64'd0);
          bubbles = 0;
          out_started = 1'b0;
        end
      end else if (out_started && !o_tvalid) begin
        bubbles++;
      end
      prev_stall = o_tvalid && !o_tready;
      prev_word  = {o_tlast, o_tdata};
    end else begin
      prev_stall  = 1'b0;
      out_started = 1'b0;
      bubbles     = 0;
    end
  end

  // reference model: effective lengths and expected output of one frame
  function automatic int eff_frame();
    if (model_frame == 0) return 1;
    if (model_frame > 256) return 256;
    return model_frame;
  endfunction

  function automatic int eff_gap();
    int f;
    f = eff_frame();
    return (model_gap > f) ? f : model_gap;
  endfunction

  task automatic expect_frame();
    int f, g;
    f = eff_frame();
    g = eff_gap();
    for (int i = f - g; i < f; i++) exp_q.push_back({1'b0, tx_buf[i]});
    for (int i = 0; i < f; i++) exp_q.push_back({(i == f - 1), tx_buf[i]});
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d);
    if (a == 8'd16) model_frame = int'(d[8:0]);
    if (a == 8'd17) model_gap = int'(d[8:0]);
  endtask

  // driver tasks (all start and end 1 time unit after a rising edge)
  task automatic write_set(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_stb = 1'b0;
    model_write(a, d);
  endtask

  task automatic fill_ramp(input int n);
    for (int i = 0; i < n; i++) tx_buf[i] = WIDTH'(i);
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) tx_buf[i] = $urandom;
  endtask

  task automatic send_frame(input int n, input int tlast_idx, input int mid_idx,
                            input logic [7:0] maddr, input logic [31:0] mdata);
    bit rdy, got;
    for (int k = 0; k < n; k++) begin
      i_tdata = tx_buf[k]; i_tlast = (k == tlast_idx); i_tvalid = 1'b1;
      if (k == mid_idx) begin
        set_stb = 1'b1; set_addr = maddr; set_data = mdata;
      end
      got = 1'b0;
      for (int t = 0; t < 3000 && !got; t++) begin
        @(negedge clk); rdy = i_tready;
        @(posedge clk); #1;
        set_stb = 1'b0;
        got = rdy;
      end
      if (k == mid_idx) model_write(maddr, mdata);
      if (!got) begin
        check("input_timeout", 64'(got), 64'd1);
        break;
      end
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 6000 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int f, err_base;
    bit seen;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #0;
    check("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_o_tlast", 64'(o_tlast), 64'd0);
    check("rst_o_tdata", 64'(o_tdata), 64'd0);
    check("rst_err", 64'(err_short), 64'd0);
    check("rst_i_tready", 64'(i_tready), 64'd1);
    check("rst_state", 64'(dbg_state), 64'(ST_FILL));

    // defaults, ramp 0..63: prefix 48..63 then 0..63, with latency/handover timing
    rdy_always = 1'b1;
    fill_ramp(64); expect_frame();
    check("exp_len_default", 64'(exp_q.size()), 64'd80);
    send_frame(64, 63, -1, 8'd0, 32'd0);
    check("busy_i_tready", 64'(i_tready), 64'd0);
    check("lat_edge0", 64'(o_tvalid), 64'd0);
    @(posedge clk); #1;
    check("lat_edge1", 64'(o_tvalid), 64'd0);
    @(posedge clk); #1;
    check("lat_edge2", 64'(o_tvalid), 64'd1);
    seen = 1'b0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge clk);
      seen = o_tvalid && o_tready && o_tlast;
    end
    check("tlast_seen", 64'(seen), 64'd1);
    check("busy_before_tlast", 64'(i_tready), 64'd0);
    @(posedge clk); #1;
    check("fill_after_tlast", 64'(i_tready), 64'd1);
    wait_drain();

    // frame 8, gap 0: three back-to-back frames, no prefix
    write_set(8'd16, 32'd8);
    write_set(8'd17, 32'd0);
    for (int fr = 0; fr < 3; fr++) begin
      fill_rand(8); expect_frame();
      send_frame(8, 7, -1, 8'd0, 32'd0);
    end
    wait_drain();

    // gap larger than frame clamps to the frame length
    write_set(8'd17, 32'd12);
    fill_ramp(8); expect_frame();
    check("exp_len_clamp", 64'(exp_q.size()), 64'd16);
    send_frame(8, 7, -1, 8'd0, 32'd0);
    wait_drain();

    // short frame discarded with an error pulse, then a normal frame
    write_set(8'd16, 32'd64);
    write_set(8'd17, 32'd16);
    err_base = err_seen;
    fill_rand(10);
    send_frame(10, 9, -1, 8'd0, 32'd0);
    repeat (5) @(posedge clk); #1;
    check("err_pulse", 64'(err_seen - err_base), 64'd1);
    check("no_out_after_err", 64'(o_tvalid), 64'd0);
    fill_ramp(64); expect_frame();
    send_frame(64, 63, -1, 8'd0, 32'd0);
    wait_drain();

    // random backpressure on the default ramp
    rdy_always = 1'b0;
    fill_ramp(64); expect_frame();
    send_frame(64, 63, -1, 8'd0, 32'd0);
    wait_drain();
    rdy_always = 1'b1;
    @(posedge clk); #1;

    // reset mid-fill, then a full ramp; mid-fill gap write applies next frame
    fill_rand(30);
    send_frame(30, -1, -1, 8'd0, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    model_frame = 64; model_gap = 16;
    check("rst2_i_tready", 64'(i_tready), 64'd1);
    check("rst2_o_tvalid", 64'(o_tvalid), 64'd0);
    fill_ramp(64); expect_frame();
    send_frame(64, 63, 20, 8'd17, 32'd4);
    wait_drain();
    check("model_gap_now4", 64'(eff_gap()), 64'd4);
    fill_ramp(64); expect_frame();
    check("exp_len_gap4", 64'(exp_q.size()), 64'd68);
    send_frame(64, 63, -1, 8'd0, 32'd0);
    wait_drain();

    // random lengths (including 0 and oversize) with random data and backpressure
    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 5))
        0: write_set(8'd16, 32'd0);
        1: write_set(8'd16, 32'd1);
        2: write_set(8'd16, 32'd300);
        3: write_set(8'd16, 32'd256);
        default: write_set(8'd16, 32'($urandom_range(2, 40)));
      endcase
      write_set(8'd17, 32'($urandom_range(0, 45)));
      rdy_always = 1'($urandom_range(0, 1));
      f = eff_frame();
      fill_rand(f); expect_frame();
      send_frame(f, f - 1, -1, 8'd0, 32'd0);
      wait_drain();
      rdy_always = 1'b1;
      @(posedge clk); #1;
    end

    check("err_total", 64'(err_seen), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
